// File: rtl/i2s_pkg.sv
// Shared I2S framing constants, common to the receiver and the transmitter.
package i2s_pkg;

    localparam logic CH_LEFT   = 1'b0;
    localparam logic CH_RIGHT  = 1'b1;
    localparam int   I2S_WIDTH = 32;

endpackage

// File: rtl/i2s_lrck_edge.sv
// LRCK two-stage delay: one-cycle slot pulse on every LRCK transition plus the current slot channel.
module i2s_lrck_edge
    import i2s_pkg::*;
(
    input  logic sclk_in,
    input  logic rst_n,
    input  logic lrck_in,
    output logic lrck_p,
    output logic lrck_ch
);

    logic lrck_d1;
    logic lrck_d2;

    always_ff @(posedge sclk_in or negedge rst_n) begin
        if (!rst_n) begin
            lrck_d1 <= CH_LEFT;
            lrck_d2 <= CH_LEFT;
        end else begin
            lrck_d1 <= lrck_in;
            lrck_d2 <= lrck_d1;
        end
    end

    assign lrck_p  = lrck_d1 ^ lrck_d2;
    assign lrck_ch = lrck_d1;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: left-justified slot capture, L/R pairing and valid/ready delivery with overrun flag.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int pdata_width = I2S_WIDTH
) (
    input  logic                   sclk_in,
    input  logic                   rst_n,
    input  logic                   lrck_in,
    input  logic                   sdata_in,
    output logic [pdata_width-1:0] pldata_out,
    output logic [pdata_width-1:0] prdata_out,
    output logic                   pvalid_out,
    input  logic                   pready_in,
    output logic                   overrun_out
);

    localparam int CW = $clog2(pdata_width + 1);

    logic                   lrck_p;
    logic                   lrck_ch;
    logic                   ended_ch;
    logic                   pair_done;
    logic                   synced;
    logic                   left_ok;
    logic [CW-1:0]          cnt;
    logic [pdata_width-1:0] shift;
    logic [pdata_width-1:0] shift_nxt;
    logic [pdata_width-1:0] left_hold;

    i2s_lrck_edge u_lrck_edge (
        .sclk_in (sclk_in),
        .rst_n   (rst_n),
        .lrck_in (lrck_in),
        .lrck_p  (lrck_p),
        .lrck_ch (lrck_ch)
    );

    assign ended_ch  = ~lrck_ch;
    assign pair_done = lrck_p & synced & left_ok & (ended_ch == CH_RIGHT);

    // Bit cnt of the slot lands at position pdata_width-1-cnt (MSB first).
    always_comb begin
        shift_nxt = shift;
        for (int i = 0; i < pdata_width; i++) begin
            if (int'(cnt) == pdata_width - 1 - i) begin
                shift_nxt[i] = sdata_in;
            end
        end
    end

    always_ff @(posedge sclk_in or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            cnt       <= '0;
            synced    <= 1'b0;
            left_ok   <= 1'b0;
            left_hold <= '0;
        end else if (lrck_p) begin
            shift <= {sdata_in, {(pdata_width - 1){1'b0}}};
            cnt   <= CW'(1);
            // The slot in progress at reset release is partial, so it never commits.
            if (!synced) begin
                synced <= 1'b1;
            end else if (ended_ch == CH_LEFT) begin
                left_hold <= shift;
                left_ok   <= 1'b1;
            end else begin
                left_ok <= 1'b0;
            end
        end else if (int'(cnt) < pdata_width) begin
            shift <= shift_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge sclk_in or negedge rst_n) begin
        if (!rst_n) begin
            pldata_out  <= '0;
            prdata_out  <= '0;
            pvalid_out  <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            overrun_out <= 1'b0;
            if (pair_done) begin
                // A transfer on the same edge frees the output register for the new pair.
                if (!pvalid_out || pready_in) begin
                    pldata_out <= left_hold;
                    prdata_out <= shift;
                    pvalid_out <= 1'b1;
                end else begin
                    overrun_out <= 1'b1;
                end
            end else if (pvalid_out && pready_in) begin
                pvalid_out <= 1'b0;
            end
        end
    end

endmodule
